reci_arbiter: RTL and testbench

- Round-robin arbiter and scheduler that shares one fixed-latency reciprocal mantissa core among NUM_REQ requesters.
- Accepts at most one operand per cycle and drives it, registered, into the core.
- Tags each operation with its requester index, realigns the tag with the core result, and returns the result on a shared registered response bus with a one-hot valid.
- Sits between the per-channel normalisation stages and the single reciprocal core.

---
 rtl/reci_arbiter.sv | 162 ++++++++++++++++
 tb/tb_reci_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reci_arbiter.sv
// Round-robin scheduler sharing one fixed-latency reciprocal core among NUM_REQ requesters.
// Optional per-requester response counters are enabled by defining RECI_ARB_PERF_CNT_EN.
module reci_arbiter #(
  parameter int FLT_WIDTH = 23,
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = 2,
  parameter int CORE_LAT  = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*FLT_WIDTH-1:0]   req_x,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           arb_hold,
  output logic [FLT_WIDTH-1:0]           core_x,
  output logic                           core_valid,
  input  logic [FLT_WIDTH-1:0]           core_result,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [FLT_WIDTH-1:0]           rsp_result,
`ifdef RECI_ARB_PERF_CNT_EN
  input  logic                           perf_clr,
  output logic [NUM_REQ*16-1:0]          perf_cnt,
`endif
  output logic                           busy
);

  logic [REQ_IDX_W-1:0] ptr_reg;
  logic                 grant_any;
  logic [REQ_IDX_W-1:0] grant_idx;
  logic [FLT_WIDTH-1:0] sel_x;

  logic [FLT_WIDTH-1:0] core_x_reg;
  logic                 core_valid_reg;
  logic [REQ_IDX_W-1:0] issue_tag_reg;

  logic                 algn_valid;
  logic [REQ_IDX_W-1:0] algn_tag;
  logic                 pipe_busy;

  logic [NUM_REQ-1:0]   rsp_valid_next;
  logic [NUM_REQ-1:0]   rsp_valid_reg;
  logic [FLT_WIDTH-1:0] rsp_result_reg;

  // Scan downward so the candidate closest to the pointer is written last and wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr_reg) + k) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant_idx = REQ_IDX_W'((int'(ptr_reg) + k) % NUM_REQ);
      end
    end
    // Grants are suppressed while held or while reset is asserted.
    if (arb_hold || !rst_n) begin
      grant_any = 1'b0;
    end
  end

  assign sel_x = req_x[int'(grant_idx)*FLT_WIDTH +: FLT_WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_dec
      assign req_ready[gi]      = grant_any && (grant_idx == REQ_IDX_W'(gi));
      assign rsp_valid_next[gi] = algn_valid && (algn_tag == REQ_IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg        <= '0;
      core_x_reg     <= '0;
      core_valid_reg <= 1'b0;
      issue_tag_reg  <= '0;
    end else begin
      core_valid_reg <= grant_any;
      if (grant_any) begin
        core_x_reg    <= sel_x;
        issue_tag_reg <= grant_idx;
        ptr_reg       <= (grant_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Tag pipe mirrors the core latency so each result meets its requester index.
  generate
    if (CORE_LAT == 0) begin : g_nopipe
      assign algn_valid = core_valid_reg;
      assign algn_tag   = issue_tag_reg;
      assign pipe_busy  = 1'b0;
    end else begin : g_pipe
      logic [CORE_LAT-1:0]  vld_reg;
      logic [REQ_IDX_W-1:0] tag_reg [CORE_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_reg[0] <= 1'b0;
          tag_reg[0] <= '0;
        end else begin
          vld_reg[0] <= core_valid_reg;
          tag_reg[0] <= issue_tag_reg;
        end
      end

      for (gi = 1; gi < CORE_LAT; gi++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vld_reg[gi] <= 1'b0;
            tag_reg[gi] <= '0;
          end else begin
            vld_reg[gi] <= vld_reg[gi-1];
            tag_reg[gi] <= tag_reg[gi-1];
          end
        end
      end

      assign algn_valid = vld_reg[CORE_LAT-1];
      assign algn_tag   = tag_reg[CORE_LAT-1];
      assign pipe_busy  = |vld_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg  <= '0;
      rsp_result_reg <= '0;
    end else begin
      rsp_valid_reg <= rsp_valid_next;
      if (algn_valid) begin
        rsp_result_reg <= core_result;
      end
    end
  end

  assign core_x     = core_x_reg;
  assign core_valid = core_valid_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_result = rsp_result_reg;
  assign busy       = core_valid_reg | pipe_busy | (|rsp_valid_reg);

`ifdef RECI_ARB_PERF_CNT_EN
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_perf
      logic [15:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (perf_clr) begin
          cnt_reg <= '0;
        end else if (rsp_valid_reg[gi] && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end

      assign perf_cnt[gi*16 +: 16] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_reci_arbiter.sv
// Directed bench for reci_arbiter: one combinational-core instance and one three-stage-core instance.
module tb_reci_arbiter;
  localparam int W  = 23;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [N-1:0]   rv0, rr0, rsv0;
  logic [N*W-1:0] rx0;
  logic           hold0, cv0, busy0;
  logic [W-1:0]   cx0, cr0, rs0;

  logic [N-1:0]   rv3, rr3, rsv3;
  logic [N*W-1:0] rx3;
  logic           hold3, cv3, busy3;
  logic [W-1:0]   cx3, cr3, rs3;
  logic [W-1:0]   d1, d2, d3;

`ifdef RECI_ARB_PERF_CNT_EN
  logic           clr0, clr3;
  logic [N*16-1:0] pc0, pc3;
`endif

  int checks   = 0;
  int failures = 0;

  // Golden reciprocal mantissa: frac(2 / (1 + m/2^23)) scaled back to 23 bits.
  function automatic logic [W-1:0] recip(input logic [W-1:0] m);
    logic [63:0] q;
    if (m == '0) return '0;
    q = (64'd1 << 47) / ((64'd1 << 23) + 64'(m));
    return q[W-1:0];
  endfunction

  assign cr0 = recip(cx0);
  always_ff @(posedge clk) begin
    d1 <= recip(cx3);
    d2 <= d1;
    d3 <= d2;
  end
  assign cr3 = d3;

  reci_arbiter #(.FLT_WIDTH(W), .NUM_REQ(N), .REQ_IDX_W(IW), .CORE_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_x(rx0), .req_ready(rr0),
    .arb_hold(hold0), .core_x(cx0), .core_valid(cv0), .core_result(cr0),
    .rsp_valid(rsv0), .rsp_result(rs0),
`ifdef RECI_ARB_PERF_CNT_EN
    .perf_clr(clr0), .perf_cnt(pc0),
`endif
    .busy(busy0)
  );

  reci_arbiter #(.FLT_WIDTH(W), .NUM_REQ(N), .REQ_IDX_W(IW), .CORE_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_x(rx3), .req_ready(rr3),
    .arb_hold(hold3), .core_x(cx3), .core_valid(cv3), .core_result(cr3),
    .rsp_valid(rsv3), .rsp_result(rs3),
`ifdef RECI_ARB_PERF_CNT_EN
    .perf_clr(clr3), .perf_cnt(pc3),
`endif
    .busy(busy3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-12s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] dreq [7];
  logic [N-1:0] dexp [7];
  logic [N-1:0] exp_g;
  int           idx;

  initial begin
    rst_n = 1'b0;
    rv0 = '0; rx0 = '0; hold0 = 1'b0;
    rv3 = '0; rx3 = '0; hold3 = 1'b0;
`ifdef RECI_ARB_PERF_CNT_EN
    clr0 = 1'b0; clr3 = 1'b0;
`endif
    for (int i = 0; i < N; i++) rx3[i*W +: W] = W'(i + 1);
    tick();
    tick();
    // Requests present during reset must not be granted.
    rv0 = 4'hF; rv3 = 4'hF;
    #1;
    check("rst_ready0", 64'(rr0), 64'h0);
    check("rst_ready3", 64'(rr3), 64'h0);
    check("rst_cvalid", 64'(cv3), 64'h0);
    check("rst_cx", 64'(cx3), 64'h0);
    check("rst_rsp", 64'({rsv0, rsv3}), 64'h0);
    check("rst_result", 64'(rs3), 64'h0);
    check("rst_busy", 64'({busy0, busy3}), 64'h0);
    rv0 = '0; rv3 = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Single requester through the combinational core.
    rv0 = 4'b0001; rx0[W-1:0] = 23'h400000;
    #1;
    check("A_grant", 64'(rr0), 64'h1);
    tick();
    rv0 = '0;
    check("A_cvalid", 64'(cv0), 64'h1);
    check("A_cx", 64'(cx0), 64'h400000);
    check("A_rsp_early", 64'(rsv0), 64'h0);
    tick();
    check("A_rsp", 64'(rsv0), 64'h1);
    check("A_result", 64'(rs0), 64'h2AAAAA);
    tick();
    check("A_rsp_off", 64'(rsv0), 64'h0);
    check("A_hold_res", 64'(rs0), 64'h2AAAAA);
    check("A_busy", 64'(busy0), 64'h0);

    // All four requesting continuously through the three-stage core.
    for (int k = 0; k < 14; k++) begin
      rv3 = (k < 8) ? 4'hF : 4'h0;
      #1;
      exp_g = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
      check($sformatf("B_grant%0d", k), 64'(rr3), 64'(exp_g));
      if (k >= 5 && k < 13) begin
        idx = (k - 5) % 4;
        check($sformatf("B_rsp%0d", k), 64'(rsv3), 64'(4'b0001 << idx));
        check($sformatf("B_res%0d", k), 64'(rs3), 64'(recip(W'(idx + 1))));
      end else begin
        check($sformatf("B_rsp%0d", k), 64'(rsv3), 64'h0);
      end
      tick();
    end

    // Two operations in flight, then hold.
    rv3 = 4'b0011;
    #1;
    check("C_grant0", 64'(rr3), 64'h1);
    tick();
    rv3 = 4'b0010;
    #1;
    check("C_grant1", 64'(rr3), 64'h2);
    tick();
    for (int j = 2; j < 8; j++) begin
      hold3 = 1'b1; rv3 = 4'hF;
      #1;
      check($sformatf("C_hold%0d", j), 64'(rr3), 64'h0);
      if (j == 5) check("C_rsp0", 64'(rsv3), 64'h1);
      if (j == 6) check("C_rsp1", 64'(rsv3), 64'h2);
      if (j == 6) check("C_busy_on", 64'(busy3), 64'h1);
      if (j == 7) check("C_busy_off", 64'(busy3), 64'h0);
      tick();
    end
    hold3 = 1'b0;

    // Pointer fairness, starting with the pointer at 2.
    dreq = '{4'b1010, 4'b1010, 4'b1000, 4'b0010, 4'b1010, 4'b0011, 4'b0010};
    dexp = '{4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0001, 4'b0010};
    for (int s = 0; s < 7; s++) begin
      rv3 = dreq[s];
      #1;
      check($sformatf("D_grant%0d", s), 64'(rr3), 64'(dexp[s]));
      tick();
    end
    rv3 = '0;
    for (int s = 0; s < 8; s++) tick();

    // Reset with three operations in flight; pointer would be 1 if not reset.
    rv3 = 4'hF;
    #1;
    check("E_g0", 64'(rr3), 64'h4);
    tick();
    check("E_g1", 64'(rr3), 64'h8);
    tick();
    check("E_g2", 64'(rr3), 64'h1);
    tick();
    check("E_busy_pre", 64'(busy3), 64'h1);
    rst_n = 1'b0;
    #1;
    check("E_ready", 64'(rr3), 64'h0);
    check("E_out", 64'({cv3, cx3, rsv3, rs3, busy3}), 64'h0);
    tick();
    tick();
    rst_n = 1'b1; rv3 = '0;
    for (int s = 0; s < 6; s++) begin
      #1;
      check($sformatf("E_quiet%0d", s), 64'({rsv3, busy3}), 64'h0);
      tick();
    end
    rv3 = 4'b1001;
    #1;
    check("E_first", 64'(rr3), 64'h1);
    tick();
    rv3 = '0;
    for (int s = 0; s < 4; s++) tick();
    check("E_rsp", 64'(rsv3), 64'h1);
    check("E_res", 64'(rs3), 64'(recip(W'(1))));
    tick();

`ifdef RECI_ARB_PERF_CNT_EN
    clr3 = 1'b1;
    tick();
    clr3 = 1'b0;
    rv3 = 4'b0100;
    for (int s = 0; s < 5; s++) tick();
    rv3 = '0;
    for (int s = 0; s < 8; s++) tick();
    check("P_five", 64'(pc3[47:32]), 64'd5);
    check("P_other", 64'(pc3[15:0]), 64'd0);
    rv3 = 4'b0100;
    tick();
    rv3 = '0;
    for (int s = 0; s < 4; s++) tick();
    check("P_rsp", 64'(rsv3), 64'h4);
    clr3 = 1'b1;
    tick();
    clr3 = 1'b0;
    check("P_clr", 64'(pc3[47:32]), 64'd0);
    rv3 = 4'b0100;
    for (int s = 0; s < 65540; s++) begin
      @(posedge clk);
    end
    #1;
    rv3 = '0;
    for (int s = 0; s < 8; s++) tick();
    check("P_sat", 64'(pc3[47:32]), 64'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
